// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor.
// Holds the 2-bit direction counter encoding, the delay-slot skip offset
// used to form the fall-through fetch PC, and the default table index width.
package branch_predictor_pkg;

  // Default number of index bits (table depth is 2**IDX_W_DEF entries).
  localparam int IDX_W_DEF = 6;

  // Fall-through PC skips the branch and its delay slot.
  localparam logic [31:0] DELAY_SLOT_OFF = 32'd8;

  // Direction counter: the upper bit alone gives the predicted direction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// bp_sat_counter: next-state function of one 2-bit saturating direction
// counter. Purely combinational; the table owns the state.
// Ports:
//   ctr_i   current counter value
//   taken_i resolved branch direction
//   ctr_o   counter value after training on taken_i
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  ctr_e ctr_i,
  input  logic taken_i,
  output ctr_e ctr_o
);

  // Step towards the resolved direction, sticking at either end.
  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != ST) ctr_o = ctr_e'(ctr_i + 2'd1);
    end else begin
      if (ctr_i != SNT) ctr_o = ctr_e'(ctr_i - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BHT/BTB that predicts direction and target
// for the PC in IF, carries the prediction across IF/ID, checks it against
// the comparator outcome in ID, raises a redirect on mispredict, trains the
// table and counts resolved / mispredicted branches.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   pc_f                        PC being fetched
//   pred_taken_f, pred_target_f combinational prediction for pc_f
//   stall_d, flush_d            hold / clear the IF/ID prediction register
//   branch_d, taken_d, target_d, pc_d   resolved branch information in ID
//   mispredict_d, redirect_pc_d combinational recovery request
//   branch_cnt, mispred_cnt     saturating performance counters
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int TAG_W = 32 - IDX_W - 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      pc_f,
  input  logic             stall_d,
  input  logic             flush_d,
  output logic             pred_taken_f,
  output logic [31:0]      pred_target_f,
  input  logic             branch_d,
  input  logic             taken_d,
  input  logic [31:0]      target_d,
  input  logic [31:0]      pc_d,
  output logic             mispredict_d,
  output logic [31:0]      redirect_pc_d,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int DEPTH = 1 << IDX_W;

  ctr_e             tbl_ctr_q   [DEPTH];
  ctr_e             tbl_ctr_d   [DEPTH];
  logic [DEPTH-1:0] tbl_valid_q, tbl_valid_d;
  logic [TAG_W-1:0] tbl_tag_q   [DEPTH];
  logic [TAG_W-1:0] tbl_tag_d   [DEPTH];
  logic [31:0]      tbl_tgt_q   [DEPTH];
  logic [31:0]      tbl_tgt_d   [DEPTH];

  logic             p_taken_q, p_taken_d;
  logic [31:0]      p_target_q, p_target_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] if_idx, id_idx;
  logic [TAG_W-1:0] if_tag, id_tag;
  logic             if_hit, id_hit;
  logic             update_en, stale_fix;
  ctr_e             ctr_next;
  logic             unused_pc_lsbs;

  assign unused_pc_lsbs = ^{pc_f[1:0], pc_d[1:0]};

  assign if_idx = pc_f[IDX_W+1:2];
  assign if_tag = pc_f[31:IDX_W+2];
  assign id_idx = pc_d[IDX_W+1:2];
  assign id_tag = pc_d[31:IDX_W+2];

  // Lookups read the registered table only, so a write this cycle shows up next cycle.
  assign if_hit        = tbl_valid_q[if_idx] && (tbl_tag_q[if_idx] == if_tag);
  assign id_hit        = tbl_valid_q[id_idx] && (tbl_tag_q[id_idx] == id_tag);
  assign pred_taken_f  = if_hit && tbl_ctr_q[if_idx][1];
  assign pred_target_f = if_hit ? tbl_tgt_q[if_idx] : 32'd0;

  assign update_en = branch_d && !stall_d;
  // A taken prediction reaching ID on a non-branch means the entry is stale.
  assign stale_fix = !branch_d && p_taken_q && !stall_d;

  bp_sat_counter u_sat (
    .ctr_i   (tbl_ctr_q[id_idx]),
    .taken_i (taken_d),
    .ctr_o   (ctr_next)
  );

  // Compare the held prediction with the resolved outcome in ID.
  always_comb begin
    mispredict_d  = p_taken_q;
    redirect_pc_d = pc_d + DELAY_SLOT_OFF;
    if (branch_d) begin
      mispredict_d = (taken_d != p_taken_q) ||
                     (taken_d && p_taken_q && (target_d != p_target_q));
      if (taken_d) redirect_pc_d = target_d;
    end
  end

  // IF/ID prediction register: flush beats stall.
  always_comb begin
    p_taken_d  = pred_taken_f;
    p_target_d = pred_target_f;
    if (flush_d) begin
      p_taken_d  = 1'b0;
      p_target_d = 32'd0;
    end else if (stall_d) begin
      p_taken_d  = p_taken_q;
      p_target_d = p_target_q;
    end
  end

  // Table training. A taken branch that misses claims the entry as weak-taken;
  // a not-taken branch that misses leaves the other branch's entry alone.
  always_comb begin
    tbl_ctr_d   = tbl_ctr_q;
    tbl_valid_d = tbl_valid_q;
    tbl_tag_d   = tbl_tag_q;
    tbl_tgt_d   = tbl_tgt_q;
    if (update_en) begin
      if (taken_d) begin
        tbl_ctr_d[id_idx]   = id_hit ? ctr_next : WT;
        tbl_valid_d[id_idx] = 1'b1;
        tbl_tag_d[id_idx]   = id_tag;
        tbl_tgt_d[id_idx]   = target_d;
      end else if (id_hit) begin
        tbl_ctr_d[id_idx] = ctr_next;
      end
    end
    if (stale_fix) tbl_valid_d[id_idx] = 1'b0;
  end

  // Saturating performance counters share the table update condition.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (update_en) begin
      if (!(&branch_cnt_q)) branch_cnt_d = branch_cnt_q + 1'b1;
      if (mispredict_d && !(&mispred_cnt_q)) mispred_cnt_d = mispred_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) tbl_ctr_q[i] <= WNT;
      tbl_valid_q   <= '0;
      p_taken_q     <= 1'b0;
      p_target_q    <= 32'd0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      tbl_ctr_q     <= tbl_ctr_d;
      tbl_valid_q   <= tbl_valid_d;
      p_taken_q     <= p_taken_d;
      p_target_q    <= p_target_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Tags and targets are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tbl_tag_q <= tbl_tag_d;
    tbl_tgt_q <= tbl_tgt_d;
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: each cycle drives the IF/ID inputs, pushes
// the expected outputs for that cycle onto a scoreboard queue, and pops and
// compares them at the falling edge.
module tb_branch_predictor;

  typedef enum {K_PT, K_PTGT, K_MIS, K_RED, K_BCNT, K_MCNT} kind_e;
  typedef struct {
    kind_e       kind;
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] pc_f;
  logic        stall_d, flush_d;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        branch_d, taken_d;
  logic [31:0] target_d, pc_d;
  logic        mispredict_d;
  logic [31:0] redirect_pc_d;
  logic [31:0] branch_cnt, mispred_cnt;

  exp_t exp_q[$];
  int   testCount = 0;
  int   failCount = 0;
  int   cycleNo   = 0;

  branch_predictor dut (
    .clk           (clk),
    .resetn        (resetn),
    .pc_f          (pc_f),
    .stall_d       (stall_d),
    .flush_d       (flush_d),
    .pred_taken_f  (pred_taken_f),
    .pred_target_f (pred_target_f),
    .branch_d      (branch_d),
    .taken_d       (taken_d),
    .target_d      (target_d),
    .pc_d          (pc_d),
    .mispredict_d  (mispredict_d),
    .redirect_pc_d (redirect_pc_d),
    .branch_cnt    (branch_cnt),
    .mispred_cnt   (mispred_cnt)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if the value differs.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testCount++;
    if (obs !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic pushExp(input kind_e k, input string name, input logic [31:0] v);
    exp_t e;
    e.kind = k;
    e.tag  = $sformatf("c%0d.%s", cycleNo, name);
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Pop every pending expectation and compare it with the matching output.
  task automatic drainScoreboard();
    exp_t e;
    logic [31:0] obs;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_PT:    obs = {31'd0, pred_taken_f};
        K_PTGT:  obs = pred_target_f;
        K_MIS:   obs = {31'd0, mispredict_d};
        K_RED:   obs = redirect_pc_d;
        K_BCNT:  obs = branch_cnt;
        default: obs = mispred_cnt;
      endcase
      checkOutput(e.tag, obs, e.val);
    end
  endtask

  // Drive one cycle of inputs with its expected outputs, check at the
  // falling edge, then advance past the next rising edge.
  task automatic applyStimulus(
    input logic [31:0] pcf, input logic st, input logic fl,
    input logic br, input logic tk, input logic [31:0] tgt, input logic [31:0] pcd,
    input logic ept, input logic [31:0] eptgt, input logic emis,
    input logic [31:0] ered, input logic [31:0] ebcnt, input logic [31:0] emcnt);
    cycleNo++;
    pc_f     = pcf;
    stall_d  = st;
    flush_d  = fl;
    branch_d = br;
    taken_d  = tk;
    target_d = tgt;
    pc_d     = pcd;
    pushExp(K_PT,   "pred_taken",  {31'd0, ept});
    pushExp(K_PTGT, "pred_target", eptgt);
    pushExp(K_MIS,  "mispredict",  {31'd0, emis});
    pushExp(K_RED,  "redirect",    ered);
    pushExp(K_BCNT, "branch_cnt",  ebcnt);
    pushExp(K_MCNT, "mispred_cnt", emcnt);
    @(negedge clk);
    drainScoreboard();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn   = 1'b0;
    pc_f     = 32'd0;
    stall_d  = 1'b0;
    flush_d  = 1'b0;
    branch_d = 1'b0;
    taken_d  = 1'b0;
    target_d = 32'd0;
    pc_d     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Reset state seen through a lookup
    applyStimulus(32'h00400010, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h00000008, 0, 0);
    // Taken branch resolved: first allocates, second strengthens, third predicted
    applyStimulus(32'h00400010, 0, 0, 1, 1, 32'h00400100, 32'h00400010, 0, 32'h0,        1, 32'h00400100, 0, 0);
    applyStimulus(32'h00400010, 0, 0, 1, 1, 32'h00400100, 32'h00400010, 1, 32'h00400100, 1, 32'h00400100, 1, 1);
    applyStimulus(32'h00400010, 0, 0, 1, 1, 32'h00400100, 32'h00400010, 1, 32'h00400100, 0, 32'h00400100, 2, 2);
    // Strong-taken branch goes not-taken: redirect to fall-through, stays taken
    applyStimulus(32'h00400010, 0, 0, 1, 0, 32'h00400100, 32'h00400010, 1, 32'h00400100, 1, 32'h00400018, 3, 2);
    applyStimulus(32'h00400010, 0, 1, 0, 0, 32'h0,        32'h00400014, 1, 32'h00400100, 1, 32'h0040001C, 4, 3);
    // Aliasing PC replaces the entry; original PC then misses
    applyStimulus(32'h00400110, 0, 0, 1, 1, 32'h00400200, 32'h00400110, 0, 32'h0,        1, 32'h00400200, 4, 3);
    applyStimulus(32'h00400010, 0, 0, 0, 0, 32'h0,        32'h00400114, 0, 32'h0,        0, 32'h0040011C, 5, 4);
    applyStimulus(32'h00400110, 0, 0, 0, 0, 32'h0,        32'h00400118, 1, 32'h00400200, 0, 32'h00400120, 5, 4);
    // Stalled branch: held register keeps mispredict up, no training or counting
    for (int i = 0; i < 3; i++)
      applyStimulus(32'h00400010, 1, 0, 1, 0, 32'h00400200, 32'h00400110, 0, 32'h0,      1, 32'h00400118, 5, 4);
    applyStimulus(32'h00400110, 0, 0, 1, 0, 32'h00400200, 32'h00400110, 1, 32'h00400200, 1, 32'h00400118, 5, 4);
    // Entry now weak-not-taken; flush with stall clears the register
    applyStimulus(32'h00400110, 1, 1, 0, 0, 32'h0,        32'h00400114, 0, 32'h00400200, 1, 32'h0040011C, 6, 5);
    applyStimulus(32'h00400110, 0, 0, 0, 0, 32'h0,        32'h00400118, 0, 32'h00400200, 0, 32'h00400120, 6, 5);
    // Reset in the middle of a taken branch update
    resetn = 1'b0;
    applyStimulus(32'h00400110, 0, 0, 1, 1, 32'h00400300, 32'h00400110, 0, 32'h00400200, 1, 32'h00400300, 6, 5);
    resetn = 1'b1;
    applyStimulus(32'h00400110, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h00000008, 0, 0);
    applyStimulus(32'h00400010, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h00000008, 0, 0);
    // Stale entry: predicted-taken PC turns out to be a non-branch
    applyStimulus(32'h00400010, 0, 0, 1, 1, 32'h00400100, 32'h00400010, 0, 32'h0,        1, 32'h00400100, 0, 0);
    applyStimulus(32'h00400010, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h00400100, 0, 32'h00000008, 1, 1);
    applyStimulus(32'h00400010, 0, 0, 0, 0, 32'h0,        32'h00400010, 1, 32'h00400100, 1, 32'h00400018, 1, 1);
    applyStimulus(32'h00400010, 0, 1, 0, 0, 32'h0,        32'h00400020, 0, 32'h0,        1, 32'h00400028, 1, 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side counterpart to the ID-stage branch comparator. It predicts branch direction and target for the PC in IF from a direct-mapped table of 2-bit counters with target buffer (BHT/BTB).
- It carries each prediction through the IF/ID boundary, checks it against the comparator outcome resolved in ID, and issues a redirect on mispredict.
- It also trains the tables and keeps performance counters.

Parameters:
- IDX_W, 6, index bits; table depth 2^IDX_W entries, indexed by pc[IDX_W+1:2].
- TAG_W, 32-IDX_W-2, tag bits = pc[31:IDX_W+2].
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous reset, active-low.
- pc_f  in  32  PC of the instruction in IF.
- stall_d  in  1  hold the IF/ID prediction register.
- flush_d  in  1  clear the IF/ID prediction register.
- pred_taken_f  out  1  predicted taken for pc_f (combinational).
- pred_target_f  out  32  predicted target for pc_f (valid when pred_taken_f).
- branch_d  in  1  instruction in ID is a conditional branch (BEQ/BNE/BGTZ/BLEZ/REGIMM).
- taken_d  in  1  comparator result for the ID instruction.
- target_d  in  32  computed branch target in ID.
- pc_d  in  32  PC of the ID instruction.
- mispredict_d  out  1  prediction held for ID was wrong (combinational).
- redirect_pc_d  out  32  correct next fetch PC when mispredict_d.
- branch_cnt  out  CNT_W  resolved branches.
- mispred_cnt  out  CNT_W  mispredicted branches.

Behaviour:
- Storage per entry:
  - ctr[1:0]: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - valid, tag, target[31:0].
- Reset (resetn=0 at a clk edge):
  - every ctr=01, every valid=0.
  - IF/ID prediction register cleared (p_taken=0, p_target=0).
  - both counters = 0.
  - reset overrides update, stall and flush.
- IF lookup (combinational, zero latency):
  - hit = valid[i] && tag[i]==pc_f[31:IDX_W+2].
  - pred_taken_f = hit && ctr[i][1].
  - pred_target_f = target[i] when hit, else 0.
  - No write-to-read bypass: a same-cycle update to entry i is visible from the next cycle only.
- IF/ID register, rising edge:
  - flush_d=1: clear to not-taken; flush wins over stall.
  - else stall_d=1: hold.
  - else capture pred_taken_f and pred_target_f.
- Mispredict check (combinational in ID). When branch_d=1:
  - mispredict_d = (taken_d != p_taken) || (taken_d && p_taken && target_d != p_target).
  - redirect_pc_d = taken_d ? target_d : pc_d+8, skipping the delay slot at pc_d+4.
- Non-branch in ID:
  - branch_d=0 with p_taken=1 (stale entry): mispredict_d=1, redirect_pc_d=pc_d+8.
  - otherwise mispredict_d=0 and redirect_pc_d=pc_d+8.
- Update: occurs at the edge when branch_d && !stall_d; index j from pc_d.
  - Taken: ctr[j] saturating +1, capped at 11; valid=1; tag and target written from pc_d/target_d.
  - Not taken: ctr[j] saturating -1, floored at 00; tag/target unchanged.
  - On a tag mismatch for a taken branch, ctr[j] is set to 10 (replace entry).
  - On a tag mismatch for a not-taken branch, no change.
  - Stale-entry correction: branch_d=0 && p_taken && !stall_d clears valid[j].
- Counters (same update condition):
  - branch_cnt increments on each update.
  - mispred_cnt increments when mispredict_d is also 1.
  - Both saturate at all-ones.
- Stall: when stall_d=1 there are no table or counter writes, but mispredict_d is still driven combinationally.
- flush_d and a branch in ID in the same cycle: the ID update still happens; only the register loaded for the next instruction is cleared.

Decomposition:
- Shared package/defines:
  - counter encodings SNT/WNT/WT/ST.
  - delay-slot offset constant 32'd8.
  - IDX_W default.
  - reuse of existing opcode defines by the ID decoder that drives branch_d.
- One sub-module, bp_sat_counter: 2-bit saturating next-state function with taken input. It is instantiated per update path, not per entry.

Test Plan:
1. Reset then pc_f=0x00400010 → pred_taken_f=0, pred_target_f=0, both counters=0.
2. Branch at pc_d=0x00400010, taken_d=1, target_d=0x00400100, resolved twice → first resolution mispredict_d=1 with redirect 0x00400100; afterwards ctr=11, and pc_f=0x00400010 gives pred_taken_f=1 and target 0x00400100.
3. Same branch with ctr=11, then taken_d=0 → mispredict_d=1, redirect 0x00400018, ctr=10; prediction is still taken next lookup.
4. Two PCs aliasing on index (0x00400010, 0x00400110 with IDX_W=6) → second taken branch replaces the tag; the first PC then misses (pred_taken_f=0).
5. stall_d=1 for 3 cycles with branch_d=1 → tables and branch_cnt unchanged, IF/ID register held; update occurs on the first unstalled edge.
6. flush_d=1 and stall_d=1 together → register cleared; a non-branch in ID afterwards gives mispredict_d=0. Drive resetn=0 mid-sequence → all state returns to reset values at that edge.
